// File: rtl/data_memory_unit_if.sv
// Purpose : request/response bundle between the CPU pipeline and the data
//           memory unit.
// Signals : MEM_READ / MEM_WRITE - request strobes (CPU -> memory)
//           ADDRESS              - 64-bit byte address of the access
//           WRITE_DATA           - 64-bit store data
//           READ_DATA            - 64-bit load result, held between reads
//           BUSY                 - request in progress (pipeline stall)
//           DONE / ERROR         - one-cycle completion / rejection pulses
//           FAULT_ADDR           - address of the most recent rejected request
// Modports: master = CPU side, slave = memory unit side.
interface data_memory_unit_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [63:0] ADDRESS;
    logic [63:0] WRITE_DATA;
    logic [63:0] READ_DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic [63:0] FAULT_ADDR;

    modport master (
        output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
        input  READ_DATA, BUSY, DONE, ERROR, FAULT_ADDR
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
        output READ_DATA, BUSY, DONE, ERROR, FAULT_ADDR
    );
endinterface

// File: rtl/data_memory_unit.sv
// Purpose : single-port doubleword data memory with a fixed number of wait
//           states per access, request validation and fault reporting.
// Ports   : CLOCK   - sole clock, rising edge
//           RESET_N - asynchronous active-low reset
//           bus     - data_memory_unit_if.slave (request/response bundle)
// Params  : DEPTH       - number of 64-bit doublewords (power of two, >= 2)
//           WAIT_CYCLES - extra wait states per access (0..7)
module data_memory_unit #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    data_memory_unit_if.slave     bus
);

    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;
    localparam logic [2:0]  WAIT_LOAD  = 3'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        ERR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [2:0]         wait_cnt;
    logic [IDX_W-1:0]   idx_q;
    logic [63:0]        data_q;
    logic               is_write_q;
    logic [63:0]        read_data_q;
    logic [63:0]        fault_addr_q;
    logic [63:0]        mem [DEPTH];

    logic request;
    logic reject;
    logic accept_ok;
    logic accept_bad;

    // Request inputs only matter in IDLE; in every other state they are ignored.
    assign request    = (state == IDLE) && (bus.MEM_READ || bus.MEM_WRITE);
    assign reject     = (bus.MEM_READ && bus.MEM_WRITE)
                     || (bus.ADDRESS[2:0] != 3'b000)
                     || (bus.ADDRESS >= ADDR_LIMIT);
    assign accept_ok  = request && !reject;
    assign accept_bad = request && reject;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept_bad) begin
                    next_state = ERR;
                end else if (accept_ok) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Wait counter: loaded at acceptance, counts down in WAIT, saturates at 0.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wait_cnt <= 3'd0;
        end else if (accept_ok) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Request capture, load result and fault address.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            idx_q        <= '0;
            data_q       <= '0;
            is_write_q   <= 1'b0;
            read_data_q  <= '0;
            fault_addr_q <= '0;
        end else begin
            if (accept_ok) begin
                idx_q      <= bus.ADDRESS[IDX_W+2:3];
                data_q     <= bus.WRITE_DATA;
                is_write_q <= bus.MEM_WRITE;
            end
            if (accept_bad) begin
                fault_addr_q <= bus.ADDRESS;
            end
            if (state == ACCESS && !is_write_q) begin
                read_data_q <= mem[idx_q];
            end
        end
    end

    // NOTE: the array has no reset; its contents survive RESET_N. A reset
    // during WAIT forces IDLE before ACCESS, so a pending write never lands.
    always_ff @(posedge CLOCK) begin
        if (state == ACCESS && is_write_q) begin
            mem[idx_q] <= data_q;
        end
    end

    assign bus.BUSY       = (state != IDLE);
    assign bus.DONE       = (state == RESP);
    assign bus.ERROR      = (state == ERR);
    assign bus.READ_DATA  = read_data_q;
    assign bus.FAULT_ADDR = fault_addr_q;

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 128: number of 64-bit doublewords in the array; power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra wait states per access; legal range 0..7.
REQ-003 SHALL have port CLOCK  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port MEM_READ  in  1  read request, driven from CONTROL_MEMREAD.
REQ-006 SHALL have port MEM_WRITE  in  1  write request, driven from CONTROL_MEMWRITE.
REQ-007 SHALL have port ADDRESS  in  64  byte address, driven from ALU_Result_Out.
REQ-008 SHALL have port WRITE_DATA  in  64  store data, driven from REG_DATA2.
REQ-009 SHALL have port READ_DATA  out  64  load result, feeding data_memory_out.
REQ-010 SHALL have port BUSY  out  1  high while a request is in progress; CPU stall.
REQ-011 SHALL have port DONE  out  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port ERROR  out  1  one-cycle pulse on a rejected request.
REQ-013 SHALL have port FAULT_ADDR  out  64  address of the most recent rejected request.

Function
REQ-014 SHALL implement states IDLE, WAIT, ACCESS, RESP, ERR; BUSY = (state != IDLE).
REQ-015 SHALL accept a request only at a rising edge in IDLE with MEM_READ|MEM_WRITE = 1; it latches ADDRESS, WRITE_DATA and the operation at that edge.
REQ-016 SHALL ignore request inputs in every state other than IDLE; nothing is queued.
REQ-017 SHALL reject at acceptance, going IDLE->ERR, when any of these holds: MEM_READ and MEM_WRITE both high; ADDRESS[2:0] != 0; ADDRESS >= DEPTH*8.
REQ-018 SHALL otherwise go IDLE->WAIT and load the wait counter with WAIT_CYCLES.
REQ-019 SHALL, at each WAIT edge, go to ACCESS if the counter is 0, else decrement the counter; WAIT lasts WAIT_CYCLES+1 cycles.
REQ-020 SHALL, at the ACCESS edge, perform the operation on index ADDRESS[log2(DEPTH)+2:3]:
- read: READ_DATA <= mem[index];
- write: mem[index] <= latched data.
The state then goes to RESP.
REQ-021 SHALL hold DONE=1 for the single RESP cycle, then return to IDLE; a request is accepted no earlier than the edge after RESP.
REQ-022 SHALL give a request accepted at edge E0 DONE high in the cycle after edge E0+WAIT_CYCLES+2.
REQ-023 SHALL, in ERR, hold ERROR=1 for one cycle, load FAULT_ADDR with the latched address at entry to ERR, make no memory access, then return to IDLE.
REQ-024 SHALL hold READ_DATA between reads; writes and errors leave it unchanged.
REQ-025 SHALL return the newly written value on a read that follows a write to the same address.
REQ-026 SHALL hold FAULT_ADDR until the next error or reset.
REQ-027 SHALL wrap the wait counter never; it saturates at 0 and is reloaded only at acceptance.

Reset
REQ-028 SHALL, on RESET_N low, immediately set the following regardless of CLOCK: state=IDLE; counter=0; BUSY=0; DONE=0; ERROR=0; READ_DATA=0; FAULT_ADDR=0.
REQ-029 SHALL abort an in-flight request on reset; a pending write is not committed.
REQ-030 SHALL leave array contents unaffected by reset.
REQ-031 SHALL accept a request at the first rising edge after RESET_N deasserts.

Verification (WAIT_CYCLES=2)
REQ-032 SHALL cover: write 0x1122334455667788 to 0x10, then read 0x10 -> each DONE four cycles after acceptance, BUSY high through RESP; READ_DATA=0x1122334455667788.
REQ-033 SHALL cover: read at 0x0C -> ERROR pulse in the cycle after acceptance; FAULT_ADDR=0x0C; READ_DATA unchanged; DONE stays 0.
REQ-034 SHALL cover: write 0xDEAD to 0x400 (out of range) -> ERROR; a subsequent read of 0x0 returns its prior value.
REQ-035 SHALL cover: MEM_READ=MEM_WRITE=1 at 0x08 -> ERROR; FAULT_ADDR=0x08; mem[1] unchanged.
REQ-036 SHALL cover: write 0xAAAAAAAAAAAAAAAA to 0x20 (holding 0x5), RESET_N low during WAIT -> all outputs 0 immediately; a later read of 0x20 returns 0x5.
REQ-037 SHALL cover: a read of 0x18 toggled onto MEM_READ/ADDRESS while BUSY -> ignored; exactly one DONE for the original request.
